// File: rtl/axis_skid_reg_array_if.sv
// rtl/axis_skid_reg_array_if.sv - AXI4-Stream beat bundle shared by the skid-register chain ports.
interface axis_skid_reg_array_if #(
   parameter int DATA_W = 32,
   parameter int USER_W = 1
);
   localparam int KEEP_W = DATA_W / 8;

   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic [USER_W-1:0] tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_skid_reg_array.sv
// rtl/axis_skid_reg_array.sv - chain of skid-buffer stages registering both the forward beat and the backward ready.
module axis_skid_reg_array #(
   parameter int N_STAGES = 2,
   parameter int DATA_W   = 32,
   parameter int USER_W   = 1,
   parameter int CNT_BITS = $clog2(2*N_STAGES+1)
) (
   input  logic                  aclk,
   input  logic                  areset,
   axis_skid_reg_array_if.slave  s_axis,
   axis_skid_reg_array_if.master m_axis,
   output logic [CNT_BITS-1:0]   occupancy
);
   localparam int KEEP_W = DATA_W / 8;
   localparam int BEAT_W = DATA_W + KEEP_W + 1 + USER_W;

   // Link j feeds stage j; link N_STAGES is the m_axis side.
   logic [N_STAGES:0] vld;
   logic [N_STAGES:0] rdy;
   logic [BEAT_W-1:0] beat [N_STAGES+1];

   assign vld[0]           = s_axis.tvalid;
   assign beat[0]          = {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
   assign rdy[N_STAGES]    = m_axis.tready;
   assign s_axis.tready    = rdy[0];
   assign m_axis.tvalid    = vld[N_STAGES];
   assign {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = beat[N_STAGES];

   for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
      logic              mv_q, mv_d, sv_q, sv_d, rdy_q, rdy_d;
      logic [BEAT_W-1:0] mdata_q, mdata_d, sdata_q, sdata_d;
      logic              in_acc, out_acc;

      assign in_acc  = vld[i] & rdy_q;
      assign out_acc = mv_q & rdy[i+1];

      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            mv_q    <= 1'b0;
            sv_q    <= 1'b0;
            rdy_q   <= 1'b0;
            mdata_q <= '0;
            sdata_q <= '0;
         end else begin
            mv_q    <= mv_d;
            sv_q    <= sv_d;
            rdy_q   <= rdy_d;
            mdata_q <= mdata_d;
            sdata_q <= sdata_d;
         end
      end

      // EMPTY/BUSY/FULL encoded as {sv,mv}; ready follows the next skid state so FULL never accepts.
      always_comb begin
         mv_d    = mv_q;
         sv_d    = sv_q;
         mdata_d = mdata_q;
         sdata_d = sdata_q;
         if (sv_q) begin
            if (out_acc) begin
               mdata_d = sdata_q;
               sv_d    = 1'b0;
            end
         end else if (in_acc) begin
            if (mv_q && !out_acc) begin
               sdata_d = beat[i];
               sv_d    = 1'b1;
            end else begin
               mdata_d = beat[i];
               mv_d    = 1'b1;
            end
         end else if (out_acc) begin
            mv_d = 1'b0;
         end
         rdy_d = ~sv_d;
      end

      assign rdy[i]    = rdy_q;
      assign vld[i+1]  = mv_q;
      assign beat[i+1] = mdata_q;
   end

   logic                s_acc, m_acc;
   logic [CNT_BITS-1:0] occ_q, occ_d;

   assign s_acc = s_axis.tvalid & rdy[0];
   assign m_acc = vld[N_STAGES] & m_axis.tready;

   always_comb begin
      occ_d = occ_q;
      if (s_acc && !m_acc) begin
         occ_d = occ_q + CNT_BITS'(1);
      end else if (!s_acc && m_acc) begin
         occ_d = occ_q - CNT_BITS'(1);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;
endmodule
